dst4x4_row_collector: RTL and testbench
=======================================

# dst4x4_row_collector

Streaming front end for the 4x4 DST datapath: accepts residual samples one row (4 samples) per cycle over a valid/ready handshake, assembles them into complete 4x4 blocks in a ping-pong register buffer, and presents each finished block, held stable, to the combinational 4x4 DST core under a second valid/ready handshake. It sits directly upstream of the transform and decouples a row-serial residual source from the block-parallel transform. Sustained throughput is one row per cycle (one block per 4 cycles).

## Interface
- IN_W, 12, signed residual sample width (matches the transform input width)
- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input row valid
- s_ready  out  1  collector can accept a row this cycle
- s_row[0:3]  in  4 x IN_W signed  one block row, index = column
- s_last  in  1  source marks the 4th (final) row of a block
- m_valid  out  1  a complete block is held on m_block
- m_ready  in  1  downstream consumes the block this cycle
- m_block[0:3][0:3]  out  16 x IN_W signed  [row][col], drives the transform input
- err_align  out  1  one-cycle pulse: s_last disagreed with the internal row count

## Operation
- Storage: two banks (0, 1) of 4x4 samples; per-bank full flag; wr_bank, wr_row (2 b), rd_bank pointers.
- Accept = s_valid && s_ready; s_ready = !full[wr_bank] && !rst.
- On accept: bank[wr_bank][wr_row] <= s_row; wr_row++.
- Accept with wr_row==3: full[wr_bank] <= 1, wr_bank toggles, wr_row <= 0. Block completes here whether or not s_last is set.
- Accept with s_last && wr_row<3 (early last): partial block discarded, wr_row <= 0, wr_bank and full unchanged, err_align pulses.
- Accept with wr_row==3 && !s_last: block completes normally, err_align pulses.
- m_valid = full[rd_bank]; m_block = bank[rd_bank] driven straight from registers, stable while m_valid && !m_ready.
- Drain = m_valid && m_ready: full[rd_bank] <= 0, rd_bank toggles.
- Simultaneous completion into one bank and drain of the other in the same cycle: both take effect; the writer never targets a full bank, so no conflict.
- No arithmetic; samples pass bit-exact, no width change.

## Timing
- Reset (rst high at an edge): full = 00, wr_bank = rd_bank = 0, wr_row = 0, all bank samples 0, err_align = 0. Outputs the cycle after: m_valid 0, m_block all 0, s_ready 1. While rst is high, s_ready = 0.
- Reset mid-block or with blocks pending: all content is dropped, no output is produced for it.
- Latency: 4th row accepted at edge N, m_valid = 1 in the cycle after N.
- Back-pressure: both banks full leaves s_ready 0. It returns to 1 in the cycle after the drain edge.
- err_align is registered: high for exactly the one cycle after the offending accept.
- Full throughput with m_ready tied 1: s_ready stays 1 continuously, one block every 4 cycles, alternating banks.

## Structure
- Package dst_pkg: N = 4 block dimension, default IN_W, typedef of a signed sample row (N x IN_W) and a signed block (N x N x IN_W) so the collector and transform share port types.
- One sub-module: dst_row_bank (4x4 register bank with row write-enable, row index, and synchronous clear), instantiated twice. Control (pointers, full flags, error detection) lives in the top.

## Test plan
- Single block: rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{-1,-2,-3,-4} with s_last on row 4, m_ready = 1 -> m_valid for exactly one cycle, the cycle after row 4 is accepted; m_block matches the rows; err_align stays 0.
- Streaming: 8 back-to-back blocks, m_ready = 1 -> s_ready never drops; blocks emerge in order with bank alternation; no duplicates or losses.
- Back-pressure: m_ready = 0 while 3 blocks are offered -> 2 blocks stored and s_ready = 0 during row 0 of block 3; m_block stays constant; pulse m_ready once -> block 1 drained, s_ready = 1 the next cycle, blocks 2 and 3 follow in order.
- Early s_last on row 2 (wr_row = 1) -> err_align pulses once; no m_valid; the next 4 rows form a correct block.
- Missing s_last on row 4 -> err_align pulses; the block is still emitted intact.
- rst asserted after 2 rows, and again with 2 full banks -> m_valid 0 and m_block 0 the cycle after the reset edge; the pending blocks are never output; a fresh block afterwards emits normally.

Source files
------------

// File: rtl/dst_pkg.sv
// Shared types for the 4x4 DST front end and transform core.
// Rows and blocks are packed so they cross ports as plain vectors.
package dst_pkg;

    localparam int N    = 4;
    localparam int IN_W = 12;

    typedef logic signed [IN_W-1:0] sample_t;
    typedef sample_t [N-1:0]        row_t;
    typedef row_t    [N-1:0]        block_t;

endpackage

// File: rtl/dst_row_bank.sv
// One 4x4 sample bank: writes a single row per cycle.
// Reset and clear both zero every sample.
module dst_row_bank
    import dst_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       we,
    input  logic [1:0] row,
    input  row_t       wdata,
    output block_t     data
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data <= '0;
        end else if (we) begin
            data[row] <= wdata;
        end
    end

endmodule

// File: rtl/dst4x4_row_collector.sv
// Row-serial to block-parallel collector feeding the 4x4 DST core.
// Two banks ping-pong so one fills while the other is held for the core.
module dst4x4_row_collector
    import dst_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   s_valid,
    output logic   s_ready,
    input  row_t   s_row,
    input  logic   s_last,
    output logic   m_valid,
    input  logic   m_ready,
    output block_t m_block,
    output logic   err_align
);

    logic [1:0] full;
    logic [1:0] full_next;
    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] wr_row;

    logic       accept;
    logic       last_row;
    logic       early_last;
    logic       missing_last;
    logic       drain;

    block_t     bank_data [2];

    assign s_ready      = !full[wr_bank] && !rst;
    assign accept       = s_valid && s_ready;
    assign last_row     = (wr_row == 2'd3);
    assign early_last   = accept && s_last && !last_row;
    assign missing_last = accept && last_row && !s_last;

    assign m_valid = full[rd_bank];
    assign m_block = bank_data[rd_bank];
    assign drain   = m_valid && m_ready;

    // Writer only targets an empty bank, so set and clear never collide.
    always_comb begin
        full_next = full;
        if (accept && last_row) begin
            full_next[wr_bank] = 1'b1;
        end
        if (drain) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_row    <= '0;
            err_align <= 1'b0;
        end else begin
            full      <= full_next;
            err_align <= early_last || missing_last;
            if (accept) begin
                if (last_row) begin
                    wr_bank <= ~wr_bank;
                    wr_row  <= '0;
                end else if (s_last) begin
                    wr_row  <= '0;
                end else begin
                    wr_row  <= wr_row + 2'd1;
                end
            end
            if (drain) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // A discarded partial block is wiped so stale rows never reappear.
    dst_row_bank u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .clr   (early_last && !wr_bank),
        .we    (accept && !wr_bank),
        .row   (wr_row),
        .wdata (s_row),
        .data  (bank_data[0])
    );

    dst_row_bank u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .clr   (early_last && wr_bank),
        .we    (accept && wr_bank),
        .row   (wr_row),
        .wdata (s_row),
        .data  (bank_data[1])
    );

endmodule

// File: tb/tb_dst4x4_row_collector.sv
// Directed bench for dst4x4_row_collector: single block, streaming,
// back-pressure, alignment errors and reset recovery.
module tb_dst4x4_row_collector;
    import dst_pkg::*;

    logic   clk;
    logic   rst;
    logic   s_valid;
    logic   s_ready;
    row_t   s_row;
    logic   s_last;
    logic   m_valid;
    logic   m_ready;
    block_t m_block;
    logic   err_align;

    int vectors;
    int miscompares;

    dst4x4_row_collector dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_row     (s_row),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_block   (m_block),
        .err_align (err_align)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [191:0] got,
                         input logic [191:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic row_t mkrow(input int a, input int b,
                                   input int c, input int d);
        row_t r;
        r[0] = sample_t'(a);
        r[1] = sample_t'(b);
        r[2] = sample_t'(c);
        r[3] = sample_t'(d);
        return r;
    endfunction

    // Holds s_valid high until the row is accepted; caller idles.
    task automatic send_row(input row_t r, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_row   = r;
        s_last  = last;
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        if (!s_ready) begin
            check("ready_timeout", 192'(s_ready), 192'(1));
            return;
        end
        step();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_row   = '0;
    endtask

    block_t eb;
    block_t ea;
    block_t ec;
    row_t   rw;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        m_ready = 1'b0;
        idle();

        // Reset state
        step();
        check("ready_in_rst", 192'(s_ready), 192'(0));
        step();
        rst = 1'b0;
        #1;
        check("rst_ready", 192'(s_ready), 192'(1));
        check("rst_valid", 192'(m_valid), 192'(0));
        check("rst_block", m_block, 192'(0));
        check("rst_err", 192'(err_align), 192'(0));

        // Single block
        m_ready = 1'b1;
        eb[0] = mkrow(1, 2, 3, 4);
        eb[1] = mkrow(5, 6, 7, 8);
        eb[2] = mkrow(9, 10, 11, 12);
        eb[3] = mkrow(-1, -2, -3, -4);
        for (int r = 0; r < 4; r++) begin
            send_row(eb[r], r == 3);
            check("single_err", 192'(err_align), 192'(0));
            check("single_valid", 192'(m_valid), 192'(r == 3));
        end
        check("single_blk", m_block, eb);
        idle();
        step();
        check("single_once", 192'(m_valid), 192'(0));

        // Streaming, 8 back-to-back blocks
        for (int b = 0; b < 8; b++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    int v;
                    v = b * 16 + r * 4 + c;
                    rw[c] = sample_t'((b % 2 == 1) ? -v : v);
                end
                eb[r] = rw;
                send_row(rw, r == 3);
                check("stream_ready", 192'(s_ready), 192'(1));
                check("stream_valid", 192'(m_valid), 192'(r == 3));
                if (r == 3) check("stream_blk", m_block, eb);
            end
        end
        idle();
        step();
        check("stream_end", 192'(m_valid), 192'(0));

        // Back-pressure
        m_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            ea[r] = mkrow(100 + r, 200 + r, -300 - r, 400 + r);
            eb[r] = mkrow(-10 - r, 20 + r, -30 - r, 40 + r);
            ec[r] = mkrow(2047, -2048, r, -r);
        end
        for (int r = 0; r < 4; r++) send_row(ea[r], r == 3);
        for (int r = 0; r < 4; r++) send_row(eb[r], r == 3);
        s_valid = 1'b1;
        s_row   = ec[0];
        s_last  = 1'b0;
        #1;
        check("bp_ready0", 192'(s_ready), 192'(0));
        check("bp_hold_a", m_block, ea);
        step();
        step();
        check("bp_ready1", 192'(s_ready), 192'(0));
        check("bp_stable", m_block, ea);
        check("bp_valid", 192'(m_valid), 192'(1));
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("bp_ready_back", 192'(s_ready), 192'(1));
        check("bp_next_b", m_block, eb);
        for (int r = 0; r < 4; r++) send_row(ec[r], r == 3);
        idle();
        check("bp_full_again", 192'(s_ready), 192'(0));
        check("bp_still_b", m_block, eb);
        m_ready = 1'b1;
        #1;
        step();
        check("bp_c_valid", 192'(m_valid), 192'(1));
        check("bp_c_blk", m_block, ec);
        step();
        check("bp_drained", 192'(m_valid), 192'(0));

        // Early s_last on the second row
        send_row(mkrow(1, 1, 1, 1), 1'b0);
        check("early_err0", 192'(err_align), 192'(0));
        send_row(mkrow(2, 2, 2, 2), 1'b1);
        check("early_err", 192'(err_align), 192'(1));
        check("early_noval", 192'(m_valid), 192'(0));
        for (int r = 0; r < 4; r++) eb[r] = mkrow(r, -r, 7 * r, -5);
        for (int r = 0; r < 4; r++) begin
            send_row(eb[r], r == 3);
            if (r == 0) check("early_err_1cyc", 192'(err_align), 192'(0));
            check("early_valid", 192'(m_valid), 192'(r == 3));
        end
        check("early_blk", m_block, eb);
        check("early_err_after", 192'(err_align), 192'(0));

        // Missing s_last on the fourth row
        for (int r = 0; r < 4; r++) eb[r] = mkrow(-7, r + 50, 3, -r - 9);
        for (int r = 0; r < 4; r++) send_row(eb[r], 1'b0);
        check("miss_err", 192'(err_align), 192'(1));
        check("miss_valid", 192'(m_valid), 192'(1));
        check("miss_blk", m_block, eb);
        idle();
        step();
        check("miss_err_clr", 192'(err_align), 192'(0));

        // Reset mid-block
        send_row(mkrow(9, 9, 9, 9), 1'b0);
        send_row(mkrow(8, 8, 8, 8), 1'b0);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst1_valid", 192'(m_valid), 192'(0));
        check("rst1_block", m_block, 192'(0));

        // Reset with both banks full
        m_ready = 1'b0;
        for (int r = 0; r < 4; r++) send_row(ea[r], r == 3);
        for (int r = 0; r < 4; r++) send_row(ec[r], r == 3);
        idle();
        check("rst2_pre", 192'(m_valid), 192'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst2_valid", 192'(m_valid), 192'(0));
        check("rst2_block", m_block, 192'(0));
        check("rst2_ready", 192'(s_ready), 192'(1));
        m_ready = 1'b1;
        step();
        step();
        check("rst2_no_stale", 192'(m_valid), 192'(0));

        // Fresh block after reset
        for (int r = 0; r < 4; r++) eb[r] = mkrow(r + 1, 0, -1, 2 * r);
        for (int r = 0; r < 4; r++) send_row(eb[r], r == 3);
        check("fresh_valid", 192'(m_valid), 192'(1));
        check("fresh_blk", m_block, eb);
        idle();
        step();
        check("fresh_once", 192'(m_valid), 192'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
